// File: rtl/vmstub_memory_pkg.sv
// Shared constants for the VM stub buffer: stub width and default page geometry.
package vmstub_memory_pkg;

  localparam int unsigned VMSTUB_WIDTH     = 19;
  localparam int unsigned MEM_SIZE_DEFAULT = 6;
  localparam int unsigned BX_BITS_DEFAULT  = 5;

endpackage

// File: rtl/vmstub_memory_if.sv
// Router-write / engine-read bundle of the VM stub buffer.
interface vmstub_memory_if
  import vmstub_memory_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter int unsigned BX_BITS  = BX_BITS_DEFAULT
);

  logic [1:0]                  start;
  logic [1:0]                  done;
  logic [VMSTUB_WIDTH-1:0]     data_in;
  logic                        enable;
  logic [BX_BITS+MEM_SIZE-1:0] read_add;
  logic [VMSTUB_WIDTH-1:0]     data_out;
  logic [MEM_SIZE-1:0]         number_out;
  logic                        overflow;

  modport master (
    output start, data_in, enable, read_add,
    input  done, data_out, number_out, overflow
  );

  modport slave (
    input  start, data_in, enable, read_add,
    output done, data_out, number_out, overflow
  );

endinterface

// File: rtl/vmstub_ram.sv
// Simple dual-port RAM, read-first, two-cycle registered read; only the output register resets.
module vmstub_ram #(
  parameter int unsigned Width     = 19,
  parameter int unsigned AddrWidth = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rd_q;
  logic [Width-1:0] rdata_q;

  // Read and write share the edge, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (clr) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vmstub_memory.sv
// VM stub buffer: one page per BX, appended by the router, served to the tracklet engine by
// {BX, index} with a registered per-page stub count.
module vmstub_memory
  import vmstub_memory_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = MEM_SIZE_DEFAULT,
  parameter int unsigned BX_BITS    = BX_BITS_DEFAULT,
  parameter int unsigned DONE_DELAY = 1
) (
  input  logic            clk,
  input  logic            reset,
  vmstub_memory_if.slave  bus
);

  localparam int NumPages = 2 ** BX_BITS;
  localparam logic [MEM_SIZE-1:0] PtrFull = '1;

  logic [BX_BITS-1:0]  wr_bx_q, wr_bx_d;
  logic [MEM_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_SIZE-1:0] cnt_q [NumPages];
  logic [MEM_SIZE-1:0] cnt_d [NumPages];
  logic [MEM_SIZE-1:0] number_q, number_d;
  logic                overflow_q, overflow_d;
  logic [1:0]          done_q [DONE_DELAY];

  logic                clear, strobe;
  logic                we;
  logic [BX_BITS-1:0]  wr_page;
  logic [MEM_SIZE-1:0] wr_idx;
  logic [BX_BITS-1:0]  rd_page;

  assign clear   = bus.start[1];
  assign strobe  = bus.start[0];
  assign rd_page = bus.read_add[BX_BITS+MEM_SIZE-1:MEM_SIZE];

  always_comb begin
    wr_bx_d    = wr_bx_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = 1'b0;
    we         = 1'b0;
    wr_page    = wr_bx_q;
    wr_idx     = wr_ptr_q;
    // The live page has no closed count yet; report its write pointer instead.
    number_d   = (rd_page == wr_bx_q) ? wr_ptr_q : cnt_q[rd_page];

    // A strobe opens the next page in the same cycle, so a concurrent write lands at its index 0.
    if (strobe) begin
      wr_page = wr_bx_q + 1'b1;
      wr_idx  = '0;
    end

    if (clear) begin
      wr_bx_d  = '1;
      wr_ptr_d = '0;
      number_d = '0;
      for (int i = 0; i < NumPages; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      if (strobe) begin
        cnt_d[wr_bx_q] = wr_ptr_q;
        cnt_d[wr_page] = '0;
        wr_bx_d        = wr_page;
        wr_ptr_d       = '0;
      end
      if (bus.enable) begin
        if (wr_idx == PtrFull) begin
          overflow_d = 1'b1;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bx_q    <= '1;
      wr_ptr_q   <= '0;
      number_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NumPages; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      wr_bx_q    <= wr_bx_d;
      wr_ptr_q   <= wr_ptr_d;
      number_q   <= number_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  // done mirrors start, including the clear bit, so only the async reset empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DONE_DELAY); i++) begin
        done_q[i] <= '0;
      end
    end else begin
      done_q[0] <= bus.start;
      for (int i = 1; i < int'(DONE_DELAY); i++) begin
        done_q[i] <= done_q[i-1];
      end
    end
  end

  vmstub_ram #(
    .Width     (VMSTUB_WIDTH),
    .AddrWidth (BX_BITS + MEM_SIZE)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .we    (we),
    .waddr ({wr_page, wr_idx}),
    .wdata (bus.data_in),
    .raddr (bus.read_add),
    .rdata (bus.data_out)
  );

  assign bus.number_out = number_q;
  assign bus.overflow   = overflow_q;
  assign bus.done       = done_q[DONE_DELAY-1];

endmodule

// File: tb/tb_vmstub_memory.sv
// Directed bench for vmstub_memory: paging, counts, overflow, wrap, read-first and clears.
module tb_vmstub_memory;
  import vmstub_memory_pkg::*;

  localparam int unsigned Ms = 6;
  localparam int unsigned Bb = 5;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic ov_seen;

  vmstub_memory_if #(.MEM_SIZE(Ms), .BX_BITS(Bb)) bus ();

  vmstub_memory #(
    .MEM_SIZE   (Ms),
    .BX_BITS    (Bb),
    .DONE_DELAY (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [Bb+Ms-1:0] addr(input int page, input int idx);
    logic [Bb-1:0] p;
    logic [Ms-1:0] i;
    p = page[Bb-1:0];
    i = idx[Ms-1:0];
    return {p, i};
  endfunction

  task automatic write_stub(input logic [1:0] st, input logic [31:0] data);
    bus.start   = st;
    bus.enable  = 1'b1;
    bus.data_in = data[VMSTUB_WIDTH-1:0];
    tick();
    bus.start   = 2'b00;
    bus.enable  = 1'b0;
  endtask

  task automatic strobe();
    bus.start = 2'b01;
    tick();
    bus.start = 2'b00;
  endtask

  task automatic num_check(input string tag, input int page, input int exp);
    bus.read_add = addr(page, 0);
    tick();
    check_eq(tag, 32'(bus.number_out), 32'(exp));
  endtask

  task automatic read_check(input string tag, input int page, input int idx,
                            input logic [31:0] exp);
    bus.read_add = addr(page, idx);
    tick();
    tick();
    check_eq(tag, 32'(bus.data_out), exp);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    bus.start    = 2'b00;
    bus.enable   = 1'b0;
    bus.data_in  = '0;
    bus.read_add = '0;
    repeat (3) tick();
    check_eq("rst_data_out", 32'(bus.data_out), 32'h0);
    check_eq("rst_number_out", 32'(bus.number_out), 32'h0);
    check_eq("rst_overflow", 32'(bus.overflow), 32'h0);
    check_eq("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b1;
    tick();

    // Page 0 gets three stubs; the closing strobe carries a write into {1,0}.
    strobe();
    check_eq("done_strobe", 32'(bus.done), 32'h1);
    write_stub(2'b00, 32'h00001);
    check_eq("done_idle", 32'(bus.done), 32'h0);
    write_stub(2'b00, 32'h00002);
    write_stub(2'b00, 32'h00003);
    write_stub(2'b01, 32'h7FFFF);

    // Back-to-back reads, one per cycle.
    bus.read_add = addr(0, 0);
    tick();
    check_eq("num_page0", 32'(bus.number_out), 32'd3);
    bus.read_add = addr(0, 1);
    tick();
    check_eq("rd_0_0", 32'(bus.data_out), 32'h00001);
    bus.read_add = addr(0, 2);
    tick();
    check_eq("rd_0_1", 32'(bus.data_out), 32'h00002);
    bus.read_add = addr(1, 0);
    tick();
    check_eq("rd_0_2", 32'(bus.data_out), 32'h00003);
    check_eq("num_page1_live", 32'(bus.number_out), 32'd1);
    tick();
    check_eq("rd_1_0", 32'(bus.data_out), 32'h7FFFF);

    // Fill page 1: indices 1..62, then the 64th write is dropped.
    ov_seen = 1'b0;
    for (int i = 1; i <= 62; i++) begin
      write_stub(2'b00, 32'h100 + 32'(i));
      ov_seen = ov_seen | bus.overflow;
    end
    check_eq("no_early_overflow", 32'(ov_seen), 32'h0);
    write_stub(2'b00, 32'h55555);
    check_eq("overflow_pulse", 32'(bus.overflow), 32'h1);
    tick();
    check_eq("overflow_end", 32'(bus.overflow), 32'h0);
    num_check("num_page1_full", 1, 63);
    read_check("rd_1_1", 1, 1, 32'h101);
    read_check("rd_1_62", 1, 62, 32'h13E);

    // Page 2 gets six stubs.
    strobe();
    for (int i = 0; i < 6; i++) begin
      write_stub(2'b00, 32'h200 + 32'(i));
    end
    num_check("num_page1_closed", 1, 63);
    num_check("num_page2_live", 2, 6);
    read_check("rd_2_5", 2, 5, 32'h205);

    // Synchronous clear mid-page after 10 writes on page 3.
    strobe();
    for (int i = 0; i < 10; i++) begin
      write_stub(2'b00, 32'h300 + 32'(i));
    end
    num_check("num_page3_live", 3, 10);
    read_check("rd_before_clear", 2, 5, 32'h205);
    write_stub(2'b10, 32'h06666);
    check_eq("clr_data_out", 32'(bus.data_out), 32'h0);
    check_eq("clr_number_out", 32'(bus.number_out), 32'h0);
    check_eq("clr_done", 32'(bus.done), 32'h2);
    num_check("clr_num_page0", 0, 0);
    num_check("clr_num_page2", 2, 0);
    num_check("clr_num_page3", 3, 0);
    write_stub(2'b01, 32'h11111);
    num_check("post_clr_page0", 0, 1);
    read_check("post_clr_rd_0_0", 0, 0, 32'h11111);

    // 33 strobes, each with one write: wr_bx wraps and page 0 is reused.
    strobe();
    bus.start = 2'b10;
    tick();
    bus.start = 2'b00;
    for (int k = 0; k <= 32; k++) begin
      write_stub(2'b01, 32'h3000 + 32'(k));
    end
    read_check("wrap_rd_0_0", 0, 0, 32'h3020);
    read_check("wrap_rd_5_0", 5, 0, 32'h3005);
    read_check("wrap_rd_31_0", 31, 0, 32'h301F);
    num_check("wrap_num_page31", 31, 1);
    num_check("wrap_num_page0_live", 0, 1);
    strobe();
    num_check("wrap_num_page0_closed", 0, 1);
    num_check("wrap_num_page1_live", 1, 0);

    // Same-cycle read and write of {2,5}: old word first, new word on the next read.
    strobe();
    for (int i = 0; i < 5; i++) begin
      write_stub(2'b00, 32'h400 + 32'(i));
    end
    bus.read_add = addr(2, 5);
    write_stub(2'b00, 32'h7ABCD);
    tick();
    check_eq("rdw_old", 32'(bus.data_out), 32'h205);
    check_eq("rdw_num_page2", 32'(bus.number_out), 32'd6);
    tick();
    check_eq("rdw_new", 32'(bus.data_out), 32'h7ABCD);

    // Async reset while a write is in flight.
    bus.start   = 2'b01;
    bus.enable  = 1'b1;
    bus.data_in = 19'h12345;
    tick();
    check_eq("pre_arst_done", 32'(bus.done), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_data_out", 32'(bus.data_out), 32'h0);
    check_eq("arst_number_out", 32'(bus.number_out), 32'h0);
    check_eq("arst_done", 32'(bus.done), 32'h0);
    check_eq("arst_overflow", 32'(bus.overflow), 32'h0);
    bus.start  = 2'b00;
    bus.enable = 1'b0;
    reset      = 1'b1;
    tick();
    write_stub(2'b01, 32'h0ABCD);
    num_check("post_arst_page0", 0, 1);
    read_check("post_arst_rd_0_0", 0, 0, 32'h0ABCD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
